// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and constants for the clock-gate controller.
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    WAKE  = 2'd1,
    ON    = 2'd2,
    DRAIN = 2'd3
  } clk_gate_state_e;

  localparam int MaxWakeCycles = 15;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tc_clk_gating.sv
// Technology clock gate: enable latched while the clock is low, ANDed with the clock.
module tc_clk_gating #(
  parameter bit IS_FUNCTIONAL = 1'b1
) (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  if (IS_FUNCTIONAL) begin : g_icg
    logic en_latch;

    // Enable latch, transparent during the low phase only
    always_latch begin
      if (!clk_i) begin
        en_latch = en_i | test_en_i;
      end
    end

    assign clk_o = en_latch & clk_i;
  end else begin : g_bypass
    assign clk_o = clk_i;
  end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate controller with req/ack handshake and idle hysteresis.
// Optional gated-cycle statistics counter enabled by CLK_GATE_CTRL_STATS_EN.
module clk_gate_ctrl #(
  parameter int WakeCycles = 2,
  parameter int IdleCycles = 8
`ifdef CLK_GATE_CTRL_STATS_EN
  ,
  parameter int StatsWidth = 32
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_en_i,
  input  logic                  req_i,
  input  logic                  busy_i,
  output logic                  ack_o,
`ifdef CLK_GATE_CTRL_STATS_EN
  output logic [StatsWidth-1:0] gated_cnt_o,
`endif
  output logic                  clk_o
);
  import clk_gate_ctrl_pkg::*;

  localparam int CntWidth = $clog2(max_int(WakeCycles, IdleCycles) + 1);
  localparam logic [CntWidth-1:0] CntZero  = {CntWidth{1'b0}};
  localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);
  localparam logic [CntWidth-1:0] WakeLoad = CntWidth'(WakeCycles - 1);
  localparam logic [CntWidth-1:0] IdleLoad = (IdleCycles > 0) ? CntWidth'(IdleCycles - 1) : CntZero;

  if (WakeCycles < 1 || WakeCycles > MaxWakeCycles) begin : g_bad_wake
    $error("clk_gate_ctrl: WakeCycles out of range");
  end
  if (IdleCycles < 0) begin : g_bad_idle
    $error("clk_gate_ctrl: IdleCycles must be non-negative");
  end

  clk_gate_state_e       state_r, state_s;
  logic [CntWidth-1:0]   cnt_r, cnt_s;
  logic                  gate_en_q, gate_en_s;
  logic                  ack_r, ack_s;

  // State, counter and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= OFF;
      cnt_r     <= CntZero;
      gate_en_q <= 1'b0;
      ack_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      gate_en_q <= gate_en_s;
      ack_r     <= ack_s;
    end
  end

  // Next-state and counter update; a cancel in DRAIN beats counter expiry
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      OFF: begin
        if (req_i) begin
          state_s = WAKE;
          cnt_s   = WakeLoad;
        end else begin
          state_s = OFF;
        end
      end
      WAKE: begin
        if (cnt_r == CntZero) begin
          state_s = ON;
        end else begin
          cnt_s = cnt_r - CntOne;
        end
      end
      ON: begin
        if (!req_i && !busy_i) begin
          if (IdleCycles == 0) begin
            state_s = OFF;
          end else begin
            state_s = DRAIN;
            cnt_s   = IdleLoad;
          end
        end else begin
          state_s = ON;
        end
      end
      DRAIN: begin
        if (req_i || busy_i) begin
          state_s = ON;
        end else if (cnt_r == CntZero) begin
          state_s = OFF;
        end else begin
          cnt_s = cnt_r - CntOne;
        end
      end
      default: begin
        state_s = OFF;
        cnt_s   = CntZero;
      end
    endcase
  end

  // Outputs derived from the next state so they register on the transition edge
  always_comb begin
    gate_en_s = 1'b0;
    ack_s     = 1'b0;
    case (state_s)
      OFF: begin
        gate_en_s = 1'b0;
        ack_s     = 1'b0;
      end
      WAKE: begin
        gate_en_s = 1'b1;
        ack_s     = 1'b0;
      end
      ON, DRAIN: begin
        gate_en_s = 1'b1;
        ack_s     = 1'b1;
      end
      default: begin
        gate_en_s = 1'b0;
        ack_s     = 1'b0;
      end
    endcase
  end

  assign ack_o = ack_r;

`ifdef CLK_GATE_CTRL_STATS_EN
  localparam logic [StatsWidth-1:0] StatsMax = {StatsWidth{1'b1}};
  localparam logic [StatsWidth-1:0] StatsOne = StatsWidth'(1);
  logic [StatsWidth-1:0] gated_cnt_r;

  // Saturating count of cycles spent in OFF
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gated_cnt_r <= {StatsWidth{1'b0}};
    end else if (state_r == OFF && gated_cnt_r != StatsMax) begin
      gated_cnt_r <= gated_cnt_r + StatsOne;
    end else begin
      gated_cnt_r <= gated_cnt_r;
    end
  end

  assign gated_cnt_o = gated_cnt_r;
`endif

  tc_clk_gating #(
    .IS_FUNCTIONAL(1'b1)
  ) u_icg (
    .clk_i    (clk_i),
    .en_i     (gate_en_q | test_en_i),
    .test_en_i(test_en_i),
    .clk_o    (clk_o)
  );

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed, table-driven bench for clk_gate_ctrl (WakeCycles=2, IdleCycles=8 and 0).
module tb_clk_gate_ctrl;
  import clk_gate_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic test_en = 1'b0;
  logic req = 1'b0;
  logic busy = 1'b0;
  logic ack, gclk;
  logic req0 = 1'b0;
  logic ack0, gclk0;
`ifdef CLK_GATE_CTRL_STATS_EN
  localparam int SW = 6;
  logic [SW-1:0] gcnt, gcnt0;
`endif

  int total = 0;
  int bad = 0;
  int clko_edges = 0;

  always #5 clk = ~clk;

  always @(posedge gclk) clko_edges++;

  clk_gate_ctrl #(
    .WakeCycles(2),
    .IdleCycles(8)
`ifdef CLK_GATE_CTRL_STATS_EN
    , .StatsWidth(SW)
`endif
  ) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .test_en_i  (test_en),
    .req_i      (req),
    .busy_i     (busy),
    .ack_o      (ack),
`ifdef CLK_GATE_CTRL_STATS_EN
    .gated_cnt_o(gcnt),
`endif
    .clk_o      (gclk)
  );

  clk_gate_ctrl #(
    .WakeCycles(2),
    .IdleCycles(0)
`ifdef CLK_GATE_CTRL_STATS_EN
    , .StatsWidth(SW)
`endif
  ) u_dut0 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .test_en_i  (1'b0),
    .req_i      (req0),
    .busy_i     (1'b0),
    .ack_o      (ack0),
`ifdef CLK_GATE_CTRL_STATS_EN
    .gated_cnt_o(gcnt0),
`endif
    .clk_o      (gclk0)
  );

  typedef struct {
    logic req;
    logic busy;
    logic ten;
    int   reps;
    logic ack;
    logic clk_run;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, return just after the rising edge
  task automatic step(input logic r, input logic b, input logic t);
    @(negedge clk);
    req = r;
    busy = b;
    test_en = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e0;
    //           req   busy  ten   reps ack   clk_o high
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0}; // OFF->WAKE
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b1}; // ack after edge N+2
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b1}; // M .. M+7
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1}; // M+8: ack falls
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b1}; // drain count 7..3
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b1}; // busy cancels
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b1}; // fresh full drain
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b1}; // test_en in OFF
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b1}; // counter now at 0
    vecs[21] = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1}; // cancel on expiry edge
    vecs[22] = '{1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b1};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1};
    vecs[24] = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", {31'd0, ack}, 32'd0);
    chk("reset_clk_o", {31'd0, gclk}, 32'd0);
    rst_n = 1'b1;

    e0 = clko_edges;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("idle_ack", {31'd0, ack}, 32'd0);
    end
    chk("idle_no_clk_edges", clko_edges - e0, 32'd0);
`ifdef CLK_GATE_CTRL_STATS_EN
    chk("gated_cnt_20", {26'd0, gcnt}, 32'd20);
`endif

    for (int i = 0; i < 25; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        step(vecs[i].req, vecs[i].busy, vecs[i].ten);
        chk($sformatf("vec%0d_%0d_ack", i, r), {31'd0, ack}, {31'd0, vecs[i].ack});
        chk($sformatf("vec%0d_%0d_clk_o", i, r), {31'd0, gclk}, {31'd0, vecs[i].clk_run});
      end
    end

    // IdleCycles=0 instance: ack drops one edge after idle is seen in ON
    req0 = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("idle0_wake_ack", {31'd0, ack0}, 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("idle0_on_ack", {31'd0, ack0}, 32'd1);
    req0 = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk("idle0_off_ack", {31'd0, ack0}, 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("idle0_clk_o_stopped", {31'd0, gclk0}, 32'd0);

    // Reset asserted mid-DRAIN
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("pre_rst_state", {30'd0, u_dut.state_r}, {30'd0, DRAIN});
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_gate_en", {31'd0, u_dut.gate_en_q}, 32'd0);
    @(negedge clk);
    #1;
    chk("rst_clk_o_low", {31'd0, gclk}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_clk_o_gated", {31'd0, gclk}, 32'd0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("post_rst_state", {30'd0, u_dut.state_r}, {30'd0, OFF});
    chk("post_rst_ack", {31'd0, ack}, 32'd0);

`ifdef CLK_GATE_CTRL_STATS_EN
    for (int i = 0; i < 70; i++) begin
      step(1'b0, 1'b0, 1'b0);
    end
    chk("gated_cnt_saturate", {26'd0, gcnt}, 32'd63);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
